// File: rtl/iq_quant_packer.sv
// IQ quantiser/packer: {I,Q} reduced to B bits each, packed MSB-first; IQ_QUANT_ROUND_EN selects round-half-up with saturation.
// Latency 1 from completing sample to o_tvalid; i_tready = ~o_tvalid | o_tready, so input stalls only while a word is held.
module iq_quant_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_W     = $clog2(OUT_WIDTH/2+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [IN_WIDTH-1:0]  i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [OUT_WIDTH-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [CNT_W-1:0]     o_tcount
);

  localparam int W = IN_WIDTH/2;
  localparam logic [CNT_W-1:0] N_B8 = CNT_W'(OUT_WIDTH/16);
  localparam logic [CNT_W-1:0] N_B4 = CNT_W'(OUT_WIDTH/8);
  localparam logic [CNT_W-1:0] N_B2 = CNT_W'(OUT_WIDTH/4);
  localparam logic [CNT_W-1:0] N_B1 = CNT_W'(OUT_WIDTH/2);

  // Returns the B-bit code right-aligned in 8 bits; mode 3 is sign only.
  function automatic logic [7:0] quant(input logic [W-1:0] c, input logic [1:0] m);
    int         b;
    logic [7:0] q;
`ifdef IQ_QUANT_ROUND_EN
    logic signed [W:0] inc, sum, r, maxv, minv;
    logic [7:0]        mask;
`endif
    b = 8 >> m;
    if (m == 2'd3) begin
      q = {7'd0, c[W-1]};
    end else begin
`ifdef IQ_QUANT_ROUND_EN
      inc  = (W > b) ? ((W+1)'(1) << (W-b-1)) : '0;
      sum  = $signed({c[W-1], c}) + inc;
      r    = sum >>> (W-b);
      maxv = ((W+1)'(1) << (b-1)) - (W+1)'(1);
      minv = ~maxv;
      if (r > maxv)      r = maxv;
      else if (r < minv) r = minv;
      mask = 8'((9'd1 << b) - 9'd1);
      q    = r[7:0] & mask;
`else
      q = 8'(c >> (W-b));
`endif
    end
    return q;
  endfunction

  logic [OUT_WIDTH-1:0] acc_q, acc_d, out_dat_q, out_dat_d, placed;
  logic [CNT_W-1:0]     fill_q, fill_d, out_cnt_q, out_cnt_d, fill_inc, n_samp;
  logic [1:0]           mode_q, mode_d, eff_mode;
  logic                 pkt_start_q, pkt_start_d;
  logic                 out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic                 accept, complete;
  logic [7:0]           qi, qq;
  logic [15:0]          samp;
  int                   bw;

  assign i_tready = ~out_vld_q | o_tready;
  assign o_tvalid = out_vld_q;
  assign o_tdata  = out_dat_q;
  assign o_tlast  = out_last_q;
  assign o_tcount = out_cnt_q;

  always_comb begin
    eff_mode    = pkt_start_q ? mode : mode_q;
    bw          = 8;
    n_samp      = N_B8;
    case (eff_mode)
      2'd0:    begin bw = 8; n_samp = N_B8; end
      2'd1:    begin bw = 4; n_samp = N_B4; end
      2'd2:    begin bw = 2; n_samp = N_B2; end
      default: begin bw = 1; n_samp = N_B1; end
    endcase
    qi       = quant(i_tdata[IN_WIDTH-1 -: W], eff_mode);
    qq       = quant(i_tdata[W-1:0], eff_mode);
    samp     = ({8'd0, qi} << bw) | {8'd0, qq};
    // Slot k lives just below slot k-1, so the first sample lands in the MSBs.
    placed   = OUT_WIDTH'(samp) << (OUT_WIDTH - 2*bw*(int'(fill_q) + 1));
    fill_inc = fill_q + CNT_W'(1);
    accept   = i_tvalid & i_tready;
    complete = accept & (i_tlast | (fill_inc == n_samp));

    acc_d       = acc_q;
    fill_d      = fill_q;
    mode_d      = mode_q;
    pkt_start_d = pkt_start_q;
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;

    if (accept) begin
      mode_d      = eff_mode;
      pkt_start_d = i_tlast;
      if (complete) begin
        acc_d  = '0;
        fill_d = '0;
      end else begin
        acc_d  = acc_q | placed;
        fill_d = fill_inc;
      end
    end

    if (complete) begin
      out_vld_d  = 1'b1;
      out_dat_d  = acc_q | placed;
      out_cnt_d  = fill_inc;
      out_last_d = i_tlast;
    end else if (o_tready) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      fill_q      <= '0;
      mode_q      <= 2'd0;
      pkt_start_q <= 1'b1;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      mode_q      <= mode_d;
      pkt_start_q <= pkt_start_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_iq_quant_packer.sv
// Bench for iq_quant_packer: directed vectors plus random packets scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_iq_quant_packer;
  localparam int IW = 32;
  localparam int OW = 32;
  localparam int CW = 5;
  localparam int W  = IW/2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [IW-1:0] i_tdata;
  logic          i_tlast, i_tvalid, i_tready;
  logic [OW-1:0] o_tdata;
  logic          o_tlast, o_tvalid;
  logic          o_tready = 1'b1;
  logic [CW-1:0] o_tcount;

  iq_quant_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tcount(o_tcount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] dat;
    logic [CW-1:0] cnt;
    logic          last;
  } wd_t;

  wd_t        exp_q[$];
  wd_t        rx_q[$];
  int         m_smp[$];
  logic [1:0] m_mode = 2'd0;
  bit         m_start = 1'b1;
  bit         in_hs = 1'b0;
  int         rdy_mode = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Quantised code of a signed component value, as plain integer arithmetic.
  function automatic int qv(input int c, input int b);
    int d, r, cc;
    if (b == 1) return (c < 0) ? 1 : 0;
    d  = 1 << (W - b);
    cc = c;
`ifdef IQ_QUANT_ROUND_EN
    cc = cc + d/2;
`endif
    r = cc / d;
    if (cc < 0 && (cc % d) != 0) r = r - 1;
    if (r > (1 << (b-1)) - 1) r = (1 << (b-1)) - 1;
    return r & ((1 << b) - 1);
  endfunction

  task automatic model_accept(input logic [IW-1:0] d, input logic last, input logic [1:0] md);
    int  b, n;
    wd_t w;
    if (m_start) m_mode = md;
    m_start = last;
    b = 8 >> m_mode;
    n = OW / (2*b);
    m_smp.push_back((qv(int'($signed(d[IW-1:W])), b) << b) | qv(int'($signed(d[W-1:0])), b));
    if (m_smp.size() == n || last) begin
      w.dat = '0;
      foreach (m_smp[k]) w.dat |= OW'(m_smp[k]) << (OW - 2*b*(k+1));
      w.cnt  = CW'(m_smp.size());
      w.last = last;
      exp_q.push_back(w);
      m_smp.delete();
    end
  endtask

  // Monitor on the falling edge: values seen here are what the next rising edge samples.
  always @(negedge clk) begin
    wd_t e;
    in_hs = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_smp.delete();
      m_start = 1'b1;
    end else begin
      chk("i_tready", i_tready, !o_tvalid || o_tready);
      if (o_tvalid && o_tready) begin
        rx_q.push_back({o_tdata, o_tcount, o_tlast});
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("o_tdata", o_tdata, e.dat);
          chk("o_tcount", o_tcount, e.cnt);
          chk("o_tlast", o_tlast, e.last);
        end
      end
      if (i_tvalid && i_tready) begin
        in_hs = 1'b1;
        model_accept(i_tdata, i_tlast, mode);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       o_tready = 1'b1;
      1:       o_tready = ($urandom_range(0, 3) != 0);
      default: o_tready = 1'b0;
    endcase
  end

  task automatic send(input logic [IW-1:0] d, input logic last);
    int t = 0;
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = last;
    do begin
      @(posedge clk); #2;
      t++;
    end while (!in_hs && t < 1000);
    chk("accept_timeout", t < 1000, 1);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || o_tvalid) && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    chk("drain_timeout", t < 500, 1);
  endtask

  task automatic rst();
    reset = 1'b1;
    #1;
    chk("rst_o_tvalid", o_tvalid, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  base;
    wd_t hold;
    logic [IW-1:0] r;
    reset = 1'b1; mode = 2'd0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    #12;
    chk("reset_o_tvalid", o_tvalid, 0);
    chk("reset_o_tdata", o_tdata, 0);
    chk("reset_o_tlast", o_tlast, 0);
    chk("reset_o_tcount", o_tcount, 0);
    chk("reset_i_tready", i_tready, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;

    // Mode 1, four samples, full word one cycle after the fourth accept.
    mode = 2'd1; rdy_mode = 0;
    send(32'h1234ABCD, 0); send(32'h5678EF01, 0); send(32'h9ABC2345, 0); send(32'hDEF06789, 0);
    chk("t1_o_tvalid", o_tvalid, 1);
`ifdef IQ_QUANT_ROUND_EN
    chk("t1_o_tdata", o_tdata, 32'h1B5FA2E6);
`else
    chk("t1_o_tdata", o_tdata, 32'h1A5E92D6);
`endif
    chk("t1_o_tcount", o_tcount, 4);
    chk("t1_o_tlast", o_tlast, 0);
    drain(); rst();

    // Mode 0, tlast on third sample flushes a partial word.
    mode = 2'd0; base = rx_q.size();
    send(32'h1234ABCD, 0); send(32'h5678EF01, 0); send(32'h9ABC2345, 1);
    drain();
    chk("t2_words", rx_q.size() - base, 2);
    if (rx_q.size() >= base + 2) begin
`ifdef IQ_QUANT_ROUND_EN
      chk("t2_dat0", rx_q[base].dat, 32'h12AC56EF);
      chk("t2_dat1", rx_q[base+1].dat, 32'h9B230000);
`else
      chk("t2_dat0", rx_q[base].dat, 32'h12AB56EF);
      chk("t2_dat1", rx_q[base+1].dat, 32'h9A230000);
`endif
      chk("t2_cnt0", rx_q[base].cnt, 2);
      chk("t2_last0", rx_q[base].last, 0);
      chk("t2_cnt1", rx_q[base+1].cnt, 1);
      chk("t2_last1", rx_q[base+1].last, 1);
    end

    // Mode 3 sign-only, 16 samples per word.
    mode = 2'd3; base = rx_q.size();
    for (int k = 0; k < 16; k++) send((k % 2) ? 32'h7FFF8000 : 32'h80007FFF, 0);
    drain();
    chk("t3_words", rx_q.size() - base, 1);
    if (rx_q.size() > base) begin
      chk("t3_dat", rx_q[base].dat, 32'h99999999);
      chk("t3_cnt", rx_q[base].cnt, 16);
    end
    rst();

    // Back-pressure over a 64-sample packet.
    mode = 2'd1; rdy_mode = 2;
    for (int k = 0; k < 4; k++) send($urandom, 0);
    chk("bp_word_pending", exp_q.size(), 1);
    hold = (exp_q.size() > 0) ? exp_q[0] : '0;
    r = $urandom;
    i_tvalid = 1'b1; i_tdata = r; i_tlast = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_o_tvalid", o_tvalid, 1);
      chk("bp_o_tdata", o_tdata, hold.dat);
      chk("bp_i_tready", i_tready, 0);
    end
    @(posedge clk); #2;
    rdy_mode = 1;
    send(r, 0);
    for (int k = 5; k < 64; k++) send($urandom, k == 63);
    rdy_mode = 0;
    drain();

    // Mode change mid-packet waits for the next packet.
    mode = 2'd0; base = rx_q.size();
    send($urandom, 0);
    mode = 2'd2;
    send($urandom, 0); send($urandom, 0); send($urandom, 1);
    for (int k = 0; k < 8; k++) send($urandom, k == 7);
    drain();
    chk("t5_words", rx_q.size() - base, 3);
    if (rx_q.size() >= base + 3) begin
      chk("t5_cnt0", rx_q[base].cnt, 2);
      chk("t5_cnt1", rx_q[base+1].cnt, 2);
      chk("t5_cnt2", rx_q[base+2].cnt, 8);
    end

    // Rounding/saturation corner values in mode 1.
    mode = 2'd1; base = rx_q.size();
    send(32'h17FF0000, 0); send(32'h18000000, 0); send(32'h79000000, 0); send(32'h00008000, 1);
    drain();
    if (rx_q.size() > base) begin
`ifdef IQ_QUANT_ROUND_EN
      chk("t6_dat", rx_q[base].dat, 32'h10207008);
`else
      chk("t6_dat", rx_q[base].dat, 32'h10107008);
`endif
    end

    // Reset mid-packet, then a fresh packet starts from slot 0.
    send($urandom, 0); send($urandom, 0);
    rst();
    for (int k = 0; k < 4; k++) send($urandom, 0);
    chk("t7_o_tvalid", o_tvalid, 1);
    chk("t7_o_tcount", o_tcount, 4);
    drain(); rst();

    // Random packets, random modes, random gaps and back-pressure.
    rdy_mode = 1;
    for (int p = 0; p < 12; p++) begin
      int len;
      mode = 2'($urandom_range(0, 3));
      len  = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        send($urandom, k == len - 1);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #2; end
      end
    end
    rdy_mode = 0;
    drain();
    chk("leftover_words", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
